sadd_drv: RTL and testbench
===========================

SADD_DRV -- requirements
Module: sadd_drv

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (WIDTH >= 2).
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to add a and b; sampled on posedge clk.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 x  output  1  serial first operand to the bit-serial adder, LSB first.
REQ-008 y  output  1  serial second operand to the bit-serial adder, LSB first.
REQ-009 s_in  input  1  serial sum returned by the adder; combinational function of x, y and the adder's stored carry.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when sum and cout become valid.
REQ-012 sum  output  WIDTH  assembled parallel result.
REQ-013 cout  output  1  final carry-out of the addition.

Function
REQ-014 FSM states SHALL be IDLE, FLUSH, SHIFT, COUT and DONE.
REQ-015 IDLE: x=y=0, busy=0; start=1 captures a and b into shift registers, clears the bit counter and moves to FLUSH.
REQ-016 FLUSH, one cycle: x=y=0, busy=1, s_in ignored; this clears the adder carry; next state SHIFT.
REQ-017 SHIFT, exactly WIDTH cycles: in cycle k (k=0..WIDTH-1), x=a_cap[k], y=b_cap[k] and busy=1; s_in SHALL be sampled into sum[k] at the end of cycle k.
REQ-018 SHIFT to COUT transition SHALL occur after the bit-(WIDTH-1) sample; the counter SHALL NOT wrap to an extra bit.
REQ-019 COUT, one cycle: x=y=0, busy=1; s_in equals the adder carry and SHALL be sampled into cout; next state DONE.
REQ-020 DONE, one cycle: done=1, busy=0, x=y=0; next state IDLE, or FLUSH if start=1 (new operands captured).
REQ-021 Latency SHALL be fixed: start accepted at edge T means done=1 in the cycle after edge T+WIDTH+2.
REQ-022 sum and cout SHALL be written only during SHIFT/COUT and SHALL hold their values from DONE until the next operation writes them.
REQ-023 start while busy=1 SHALL be ignored, with no effect on captured operands or the counter.
REQ-024 Changes on a/b after acceptance SHALL NOT affect the operation in flight.
REQ-025 sum SHALL equal (a+b) mod 2^WIDTH and cout SHALL equal bit WIDTH of a+b, for all operand values.

Reset
REQ-026 rst=1 at a posedge SHALL force IDLE, x=0, y=0, busy=0, done=0, sum=0, cout=0, counter=0 and operand registers=0, overriding start.
REQ-027 rst asserted mid-operation (any state) SHALL abort the operation with no done pulse; the next operation SHALL produce a correct result because of FLUSH.

Verification
REQ-028 WIDTH=8, a=0x05, b=0x03, start one cycle, with a behavioural bit-serial adder on x/y/s_in -> done exactly 10 cycles after the accept edge, sum=0x08, cout=0.
REQ-029 a=0xFF, b=0x01 -> sum=0x00, cout=1; immediately following a=0x00, b=0x00 -> sum=0x00, cout=0 (no stale carry).
REQ-030 a=0xFF, b=0xFF -> sum=0xFE, cout=1; x/y bit sequence observed LSB first, one bit per cycle for 8 cycles.
REQ-031 start held high through DONE -> DONE goes directly to FLUSH, back-to-back results correct, one done pulse per operation.
REQ-032 start pulsed and a/b changed during SHIFT -> ignored; the result matches the originally captured operands.
REQ-033 rst pulsed during SHIFT bit 3 -> all outputs 0 next cycle, no done; a subsequent 0x7F+0x01 -> sum=0x80, cout=0.

Source files
------------

// File: rtl/sadd_if.sv
// Bundle of the parallel request/result signals and the serial adder link of sadd_drv.
interface sadd_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             x;
  logic             y;
  logic             s_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, s_in,
    input  x, y, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, s_in,
    output x, y, busy, done, sum, cout
  );
endinterface

// File: rtl/sadd_drv.sv
// Drives an external bit-serial adder LSB first and assembles its serial sum
// into a parallel result, with a carry-clearing flush cycle before every add.
module sadd_drv #(
  parameter int WIDTH = 8
) (
  input logic   clk,
  input logic   rst,
  sadd_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    SHIFT = 3'd2,
    COUT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic             cout_r, cout_s;
  logic             x_r, x_s;
  logic             y_r, y_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // Next-state, datapath and next-output decode; outputs are precomputed from
  // the next state so every port comes straight from a flop.
  always_comb begin
    state_s = state_r;
    a_s     = a_r;
    b_s     = b_r;
    sum_s   = sum_r;
    cnt_s   = cnt_r;
    cout_s  = cout_r;
    case (state_r)
      IDLE, DONE: begin
        if (bus.start) begin
          a_s     = bus.a;
          b_s     = bus.b;
          cnt_s   = {CW{1'b0}};
          state_s = FLUSH;
        end else begin
          state_s = IDLE;
        end
      end
      FLUSH: begin
        cnt_s   = {CW{1'b0}};
        state_s = SHIFT;
      end
      SHIFT: begin
        sum_s[cnt_r] = bus.s_in;
        a_s          = {1'b0, a_r[WIDTH-1:1]};
        b_s          = {1'b0, b_r[WIDTH-1:1]};
        // Leave on the last bit instead of wrapping the counter.
        if (cnt_r == CW'(WIDTH - 1)) begin
          state_s = COUT;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      COUT: begin
        cout_s  = bus.s_in;
        state_s = DONE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (state_s == SHIFT) begin
      x_s = a_s[0];
      y_s = b_s[0];
    end else begin
      x_s = 1'b0;
      y_s = 1'b0;
    end
    busy_s = (state_s == FLUSH) || (state_s == SHIFT) || (state_s == COUT);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      cnt_r   <= {CW{1'b0}};
      cout_r  <= 1'b0;
      x_r     <= 1'b0;
      y_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      sum_r   <= sum_s;
      cnt_r   <= cnt_s;
      cout_r  <= cout_s;
      x_r     <= x_s;
      y_r     <= y_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.x    = x_r;
  assign bus.y    = y_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = sum_r;
  assign bus.cout = cout_r;
endmodule

// File: tb/tb_sadd_drv.sv
// Scoreboard bench for sadd_drv: directed operand pairs against a behavioural
// bit-serial adder, with expected results queued by the driver and popped on done.
module tb_sadd_drv;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  sadd_if #(.WIDTH(W)) bus ();

  sadd_drv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural serial adder; carry starts at 1 so only the flush can clear it.
  logic carry = 1'b1;
  assign bus.s_in = bus.x ^ bus.y ^ carry;
  always @(posedge clk) carry <= (bus.x & bus.y) | (carry & (bus.x ^ bus.y));

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    int           acc_edge;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [W-1:0] s, input logic c, input int e);
    exp_t t;
    t.s = s;
    t.c = c;
    t.acc_edge = e;
    exp_q.push_back(t);
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        exp_t t;
        t = exp_q.pop_front();
        check("sum", 32'(bus.sum), 32'(t.s));
        check("cout", 32'(bus.cout), 32'(t.c));
        check("latency", 32'(cyc), 32'(t.acc_edge + W + 2));
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic [W-1:0] es, input logic ec);
    @(negedge clk);
    bus.a = ta;
    bus.b = tb_v;
    bus.start = 1'b1;
    push(es, ec, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = ~ta;
    bus.b = ~tb_v;
    check("flush_xyb", {29'd0, bus.x, bus.y, bus.busy}, 32'd1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("shift_xyb", {29'd0, bus.x, bus.y, bus.busy}, {29'd0, ta[k], tb_v[k], 1'b1});
    end
    @(negedge clk);
    check("cout_xyb", {29'd0, bus.x, bus.y, bus.busy}, 32'd1);
    @(negedge clk);
    check("done_state", {29'd0, bus.done, bus.busy, bus.x | bus.y}, 32'd4);
    @(negedge clk);
    check("done_pulse", 32'(bus.done), 32'd0);
    check("sum_hold", 32'(bus.sum), 32'(es));
    check("cout_hold", 32'(bus.cout), 32'(ec));
  endtask

  initial begin
    int e1;
    bus.start = 1'b1;
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_outs", {20'd0, bus.x, bus.y, bus.busy, bus.done, bus.sum}, 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("idle_after_rst", {29'd0, bus.busy, bus.done, bus.x}, 32'd0);

    run_op(8'h05, 8'h03, 8'h08, 1'b0);
    run_op(8'hFF, 8'h01, 8'h00, 1'b1);
    run_op(8'h00, 8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op(8'h80, 8'h80, 8'h00, 1'b1);
    run_op(8'hA5, 8'h5A, 8'hFF, 1'b0);

    // start held through DONE: second op is accepted on the edge leaving DONE
    @(negedge clk);
    bus.a = 8'h12;
    bus.b = 8'h34;
    bus.start = 1'b1;
    e1 = cyc + 1;
    push(8'h46, 1'b0, e1);
    push(8'h2C, 1'b1, e1 + W + 3);
    @(negedge clk);
    bus.a = 8'hC8;
    bus.b = 8'h64;
    repeat (W + 2) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (W + 6) @(negedge clk);

    // start and new operands during SHIFT are ignored
    @(negedge clk);
    bus.a = 8'h3C;
    bus.b = 8'h45;
    bus.start = 1'b1;
    push(8'h81, 1'b0, cyc + 1);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'hFF;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (W + 2) @(negedge clk);

    // reset during SHIFT bit 3 of an operation that leaves the adder carry set
    @(negedge clk);
    bus.a = 8'hFF;
    bus.b = 8'h01;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outs", {20'd0, bus.x, bus.y, bus.busy, bus.done, bus.sum}, 32'd0);
    check("abort_cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    repeat (W + 4) @(negedge clk);
    run_op(8'h7F, 8'h01, 8'h80, 1'b0);

    repeat (3) @(negedge clk);
    check("pending_ops", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
